// File: rtl/fixed_div_dispatcher_pkg.sv
// Shared types and constants for the fixed-point divide dispatcher.
// Default Q16.16 operands; request layout is {num, den, tag}.
package fixed_div_dispatcher_pkg;

  localparam int unsigned I_W   = 16;
  localparam int unsigned F_W   = 16;
  localparam int unsigned Q_W   = I_W + F_W;
  localparam int unsigned TAG_W = 4;

  localparam logic [Q_W-1:0] DIV0_QUOT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_REARM
  } state_t;

  typedef struct packed {
    logic [Q_W-1:0]   num;
    logic [Q_W-1:0]   den;
    logic [TAG_W-1:0] tag;
  } req_t;

endpackage

// File: rtl/fixed_div_dispatcher_fifo.sv
// In-order request FIFO; head is visible the cycle after its push.
// Pointers carry an extra wrap bit to tell full from empty.
module div_req_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 68
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/fixed_div_dispatcher.sv
// Front end for the iterative divider: queues tagged requests, issues one
// at a time, handles divide-by-zero and watchdog, re-arms the engine.
module fixed_div_dispatcher
  import fixed_div_dispatcher_pkg::*;
#(
  parameter int I_WIDTH   = I_W,
  parameter int F_WIDTH   = F_W,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = TAG_W,
  parameter int TIMEOUT   = 63
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [I_WIDTH+F_WIDTH-1:0] s_num,
  input  logic [I_WIDTH+F_WIDTH-1:0] s_den,
  input  logic [TAG_WIDTH-1:0]       s_tag,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [I_WIDTH+F_WIDTH-1:0] m_quot,
  output logic [TAG_WIDTH-1:0]       m_tag,
  output logic                       m_div0,
  output logic                       m_timeout,
  input  logic                       div_ready,
  output logic                       div_in_valid,
  output logic [I_WIDTH+F_WIDTH-1:0] div_n,
  output logic [I_WIDTH+F_WIDTH-1:0] div_d,
  input  logic                       div_out_valid,
  input  logic [I_WIDTH+F_WIDTH-1:0] div_out,
  output logic                       div_rst,
  output logic                       busy
);

  localparam int QW = I_WIDTH + F_WIDTH;
  localparam int DW = 2*QW + TAG_WIDTH;
  localparam int WW = $clog2(TIMEOUT+1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT-1);

  state_t state_q, state_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic [DW-1:0]        head;
  logic [QW-1:0]        head_num;
  logic [QW-1:0]        head_den;
  logic [TAG_WIDTH-1:0] head_tag;
  logic                 head_zero;

  logic [QW-1:0]        num_q, num_d;
  logic [QW-1:0]        den_q, den_d;
  logic [TAG_WIDTH-1:0] optag_q, optag_d;
  logic [QW-1:0]        quot_q, quot_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 div0_q, div0_d;
  logic                 to_q, to_d;
  logic                 used_q, used_d;
  logic                 rearm_q, rearm_d;
  logic [WW-1:0]        wd_q, wd_d;

  assign {head_num, head_den, head_tag} = head;
  assign head_zero = head_den == '0;
  assign s_ready   = !fifo_full && !rst;
  assign pop       = (state_q == S_IDLE) && !fifo_empty &&
                     (head_zero || div_ready);

  div_req_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid && s_ready),
    .din_i   ({s_num, s_den, s_tag}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) state_d = head_zero ? S_RESP : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (div_out_valid || wd_q == WD_LAST) state_d = S_RESP;
      end
      S_RESP: begin
        if (m_ready) state_d = used_q ? S_REARM : S_IDLE;
      end
      S_REARM: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    num_d        = num_q;
    den_d        = den_q;
    optag_d      = optag_q;
    quot_d       = quot_q;
    tag_d        = tag_q;
    div0_d       = div0_q;
    to_d         = to_q;
    used_d       = used_q;
    wd_d         = wd_q;
    rearm_d      = 1'b0;
    div_in_valid = 1'b0;
    m_valid      = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (pop && head_zero) begin
          quot_d = '1;
          div0_d = 1'b1;
          to_d   = 1'b0;
          tag_d  = head_tag;
          used_d = 1'b0;
        end else if (pop) begin
          num_d   = head_num;
          den_d   = head_den;
          optag_d = head_tag;
          used_d  = 1'b1;
        end
      end
      (state_q == S_ISSUE): begin
        div_in_valid = 1'b1;
        wd_d         = '0;
      end
      (state_q == S_WAIT): begin
        wd_d = wd_q + WW'(1);
        // A late result still beats the watchdog in the same cycle.
        if (div_out_valid) begin
          quot_d  = div_out;
          div0_d  = 1'b0;
          to_d    = 1'b0;
          tag_d   = optag_q;
          rearm_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          quot_d  = '0;
          div0_d  = 1'b0;
          to_d    = 1'b1;
          tag_d   = optag_q;
          rearm_d = 1'b1;
        end
      end
      (state_q == S_RESP): m_valid = 1'b1;
      (state_q == S_REARM): ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q   <= '0;
      den_q   <= '0;
      optag_q <= '0;
      quot_q  <= '0;
      tag_q   <= '0;
      div0_q  <= 1'b0;
      to_q    <= 1'b0;
      used_q  <= 1'b0;
      rearm_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      num_q   <= num_d;
      den_q   <= den_d;
      optag_q <= optag_d;
      quot_q  <= quot_d;
      tag_q   <= tag_d;
      div0_q  <= div0_d;
      to_q    <= to_d;
      used_q  <= used_d;
      rearm_q <= rearm_d;
      wd_q    <= wd_d;
    end
  end

  assign m_quot    = quot_q;
  assign m_tag     = tag_q;
  assign m_div0    = div0_q;
  assign m_timeout = to_q;
  assign div_n     = num_q;
  assign div_d     = den_q;
  assign div_rst   = rst || rearm_q;
  assign busy      = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_fixed_div_dispatcher.sv
// Randomised bench for fixed_div_dispatcher with a behavioural engine
// and a queue-based reference of expected results.
module tb_fixed_div_dispatcher;
  import fixed_div_dispatcher_pkg::*;

  localparam int TO = 63;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  tag;
    logic        d0;
    logic        to;
  } exp_t;

  logic        clk, rst;
  logic        s_valid, s_ready;
  logic [31:0] s_num, s_den;
  logic [3:0]  s_tag;
  logic        m_valid, m_ready;
  logic [31:0] m_quot;
  logic [3:0]  m_tag;
  logic        m_div0, m_timeout;
  logic        div_ready, div_in_valid, div_out_valid, div_rst;
  logic [31:0] div_n, div_d, div_out;
  logic        busy;

  int checks, errors;
  int cyc;
  int mr_mode;
  int eng_mode, eng_lat;
  bit eng_rand;

  fixed_div_dispatcher #(
    .I_WIDTH(16), .F_WIDTH(16), .DEPTH(4),
    .TAG_WIDTH(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_num(s_num), .s_den(s_den), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_quot(m_quot), .m_tag(m_tag),
    .m_div0(m_div0), .m_timeout(m_timeout),
    .div_ready(div_ready), .div_in_valid(div_in_valid),
    .div_n(div_n), .div_d(div_d),
    .div_out_valid(div_out_valid), .div_out(div_out),
    .div_rst(div_rst), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qdiv(input logic [31:0] n,
                                       input logic [31:0] d);
    logic [63:0] w;
    w = {16'h0, n, 16'h0} / {32'h0, d};
    return w[31:0];
  endfunction

  // Expected outcome of one request, from the request and engine behaviour.
  function automatic exp_t model(input logic [31:0] n, input logic [31:0] d,
                                 input logic [3:0] t, input int mode);
    exp_t e;
    e.tag = t;
    e.d0  = 1'b0;
    e.to  = 1'b0;
    if (d == 0) begin
      e.q  = DIV0_QUOT;
      e.d0 = 1'b1;
    end else if (mode == 1) begin
      e.q  = '0;
      e.to = 1'b1;
    end else begin
      e.q = qdiv(n, d);
    end
    return e;
  endfunction

  // Engine: mode 0 answers after a latency, 1 never answers,
  // 2 answers exactly in the last watchdog cycle.
  logic        eng_busy, eng_done;
  int          eng_cnt;
  logic [31:0] eng_res;
  assign div_ready     = !eng_busy;
  assign div_out_valid = eng_done;
  assign div_out       = eng_res;

  always @(posedge clk) begin
    if (div_rst) begin
      eng_busy <= 1'b0;
      eng_done <= 1'b0;
    end else if (div_in_valid && !eng_busy) begin
      eng_busy <= 1'b1;
      eng_res  <= qdiv(div_n, div_d);
      if (eng_mode == 2)  eng_cnt <= TO - 1;
      else if (eng_rand)  eng_cnt <= int'($urandom_range(1, 20));
      else                eng_cnt <= eng_lat;
    end else if (eng_busy && !eng_done && eng_mode != 1) begin
      if (eng_cnt <= 1) eng_done <= 1'b1;
      else              eng_cnt  <= eng_cnt - 1;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  exp_t        exp_q[$];
  logic [3:0]  got_tags[$];
  int          push_cyc, issue_cyc, dov_cyc, resp_cyc;
  int          n_issue, n_rearm, n_resp;
  logic [31:0] last_q;
  logic [3:0]  last_tag;
  logic        last_d0, last_to;

  initial begin
    logic        pmv, pmr, pdov;
    logic [31:0] pq;
    logic [3:0]  ptag;
    exp_t        e;
    pmv = 0; pmr = 0; pdov = 0; pq = 0; ptag = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        pmv = 0;
        pdov = 0;
      end else begin
        if (s_valid && s_ready) begin
          exp_q.push_back(model(s_num, s_den, s_tag, eng_mode));
          push_cyc = cyc;
        end
        if (div_in_valid) begin
          n_issue++;
          issue_cyc = cyc;
        end
        if (div_rst) n_rearm++;
        if (div_out_valid && !pdov) dov_cyc = cyc;
        if (m_valid && !pmv) resp_cyc = cyc;
        if (pmv && !pmr) begin
          chk("hold_valid", 64'(m_valid), 64'(1));
          chk("hold_quot", 64'(m_quot), 64'(pq));
          chk("hold_tag", 64'(m_tag), 64'(ptag));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_result", 64'(m_tag), 64'(16));
          end else begin
            e = exp_q.pop_front();
            chk("quot", 64'(m_quot), 64'(e.q));
            chk("tag", 64'(m_tag), 64'(e.tag));
            chk("div0", 64'(m_div0), 64'(e.d0));
            chk("timeout", 64'(m_timeout), 64'(e.to));
          end
          n_resp++;
          got_tags.push_back(m_tag);
          last_q = m_quot; last_tag = m_tag;
          last_d0 = m_div0; last_to = m_timeout;
        end
        pmv = m_valid; pmr = m_ready; pdov = div_out_valid;
        pq = m_quot; ptag = m_tag;
      end
    end
  end

  task automatic send(input logic [31:0] n, input logic [31:0] d,
                      input logic [3:0] t);
    int  w;
    bit  acc;
    w = 0;
    acc = 0;
    s_valid = 1'b1; s_num = n; s_den = d; s_tag = t;
    while (!acc && w < 500) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      w++;
    end
    if (!acc) chk("send_wait", 64'(s_ready), 64'(1));
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while ((busy || m_valid || exp_q.size() != 0) && w < budget) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= budget)
      chk("idle_wait", 64'({exp_q.size() != 0, busy, m_valid}), 64'(0));
  endtask

  initial begin
    int i0, r0, g0, idx, first_full;
    checks = 0; errors = 0;
    mr_mode = 1; eng_mode = 0; eng_lat = 3; eng_rand = 0;
    rst = 1'b1; s_valid = 1'b0; s_num = 0; s_den = 0; s_tag = 0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_div_rst", 64'(div_rst), 64'(1));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_m_quot", 64'(m_quot), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_s_ready", 64'(s_ready), 64'(1));
    chk("post_outs", 64'({m_valid, busy, div_in_valid, m_div0, m_timeout}),
        64'(0));
    chk("post_data", 64'({m_quot, m_tag}), 64'(0));
    chk("post_div_nd", 64'({div_n, div_d}), 64'(0));
    chk("post_div_rst", 64'(div_rst), 64'(0));
    @(posedge clk);
    #1;

    // Plain divide through the engine.
    i0 = n_issue; r0 = n_rearm;
    send(32'h0006_0000, 32'h0002_0000, 4'd3);
    wait_idle(300);
    chk("d1_quot", 64'(last_q), 64'(32'h0003_0000));
    chk("d1_tag", 64'(last_tag), 64'(3));
    chk("d1_issues", 64'(n_issue - i0), 64'(1));
    chk("d1_rearms", 64'(n_rearm - r0), 64'(1));
    chk("d1_issue_lat", 64'(issue_cyc - push_cyc), 64'(2));
    chk("d1_resp_lat", 64'(resp_cyc - dov_cyc), 64'(1));

    // Divide by zero is answered locally.
    i0 = n_issue; r0 = n_rearm;
    send(32'h0001_0000, 32'h0, 4'd7);
    wait_idle(300);
    chk("z_lat", 64'(resp_cyc - push_cyc), 64'(2));
    chk("z_quot", 64'(last_q), 64'(32'hFFFF_FFFF));
    chk("z_flag", 64'(last_d0), 64'(1));
    chk("z_tag", 64'(last_tag), 64'(7));
    chk("z_issues", 64'(n_issue - i0), 64'(0));
    chk("z_rearms", 64'(n_rearm - r0), 64'(0));

    // Engine never answers.
    eng_mode = 1;
    r0 = n_rearm;
    send(32'h0005_0000, 32'h0001_0000, 4'd2);
    wait_idle(400);
    chk("h_flag", 64'(last_to), 64'(1));
    chk("h_quot", 64'(last_q), 64'(0));
    chk("h_lat", 64'(resp_cyc - issue_cyc), 64'(TO + 1));
    chk("h_rearms", 64'(n_rearm - r0), 64'(1));
    eng_mode = 0;
    send(32'h0008_0000, 32'h0002_0000, 4'd4);
    wait_idle(300);
    chk("h_next_quot", 64'(last_q), 64'(32'h0004_0000));
    chk("h_next_flag", 64'(last_to), 64'(0));

    // Backpressure: one in flight plus four queued.
    mr_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    g0 = got_tags.size();
    idx = 0;
    first_full = -1;
    s_valid = 1'b1;
    for (int c = 0; c < 80 && idx < 6; c++) begin
      s_num = 32'((idx + 1) << 16);
      s_den = 32'h0001_0000;
      s_tag = 4'(idx);
      @(negedge clk);
      if (s_ready) idx++;
      else if (first_full < 0) first_full = idx;
      @(posedge clk);
      #1;
      if (first_full >= 0 && c > 12) mr_mode = 1;
    end
    s_valid = 1'b0;
    mr_mode = 1;
    chk("bp_full_at", 64'(first_full), 64'(5));
    wait_idle(600);
    chk("bp_count", 64'(got_tags.size() - g0), 64'(6));
    for (int k = 0; k < 6; k++) begin
      if (g0 + k < got_tags.size())
        chk("bp_order", 64'(got_tags[g0 + k]), 64'(k));
    end

    // Reset while waiting on the engine with two requests queued.
    eng_lat = 40;
    i0 = n_issue;
    send(32'h0009_0000, 32'h0003_0000, 4'd1);
    send(32'h0002_0000, 32'h0001_0000, 4'd2);
    send(32'h0004_0000, 32'h0001_0000, 4'd3);
    repeat (8) @(posedge clk);
    #1;
    chk("r_issued", 64'(n_issue - i0), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("r_div_rst", 64'(div_rst), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("r_m_valid", 64'(m_valid), 64'(0));
    chk("r_busy", 64'(busy), 64'(0));
    chk("r_s_ready", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;
    eng_lat = 3;
    r0 = n_resp;
    repeat (80) @(posedge clk);
    #1;
    chk("r_no_result", 64'(n_resp - r0), 64'(0));
    send(32'h0009_0000, 32'h0003_0000, 4'd5);
    wait_idle(300);
    chk("r_quot", 64'(last_q), 64'(32'h0003_0000));
    chk("r_tag", 64'(last_tag), 64'(5));

    // Result and watchdog expiry in the same cycle.
    eng_mode = 2;
    send(32'h0007_0000, 32'h0002_0000, 4'd9);
    wait_idle(400);
    chk("c_flag", 64'(last_to), 64'(0));
    chk("c_quot", 64'(last_q), 64'(32'h0003_8000));
    chk("c_lat", 64'(resp_cyc - issue_cyc), 64'(TO + 1));
    eng_mode = 0;

    // Random traffic with random backpressure and engine latency.
    eng_rand = 1;
    mr_mode = 2;
    r0 = n_resp;
    for (int k = 0; k < 40; k++) begin
      send($urandom, ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom,
           4'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle(3000);
    chk("rnd_count", 64'(n_resp - r0), 64'(40));
    mr_mode = 1;
    eng_rand = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
